drum_host_driver: RTL and testbench



---
 rtl/drum_host_pkg.sv | 44 ++++
 rtl/drum_host_driver.sv | 156 +++++++++++++++
 tb/tb_drum_host_driver.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/drum_host_pkg.sv
// Shared types and constants for the DRUM tile host driver, plus a behavioural
// model of the tile's approximate signed product used by benches.
package drum_host_pkg;

   typedef enum logic [3:0] {
      ST_INIT,
      ST_IDLE,
      ST_WR_A,
      ST_WR_B,
      ST_SETTLE,
      ST_RD_LO,
      ST_RD_HI,
      ST_CAP_HI,
      ST_RESP
   } state_e;

   localparam logic [4:0] OP_A_ADDR = 5'd0;
   localparam logic [4:0] OP_B_ADDR = 5'd1;
   localparam int         WR_BIT    = 7;
   localparam logic [7:0] IDLE_UI   = 8'h10;

   // Keep the leading two bits of a magnitude and force the lower kept bit to 1.
   function automatic logic [7:0] drum_trunc(input logic [7:0] m);
      int msb;
      msb = -1;
      for (int i = 0; i < 8; i++) begin
         if (m[i]) msb = i;
      end
      if (msb < 2) return m;
      return 8'(8'd3 << (msb - 1));
   endfunction

   // Signs are folded by ones' complement on the way in and out, as the tile does.
   function automatic logic [15:0] drum_ref(input logic [7:0] a, input logic [7:0] b);
      logic [7:0]  ma;
      logic [7:0]  mb;
      logic [15:0] p;
      ma = a ^ {8{a[7]}};
      mb = b ^ {8{b[7]}};
      p  = 16'(drum_trunc(ma)) * 16'(drum_trunc(mb));
      return p ^ {16{a[7] ^ b[7]}};
   endfunction

endpackage

// File: rtl/drum_host_driver.sv
// Host-side master for the DRUM tile pins: writes the operand pair, reads the
// stored product back, and returns it on a valid/ready response port.
module drum_host_driver
   import drum_host_pkg::*;
#(
   parameter int INIT_WAIT     = 8,
   parameter int SETTLE_CYCLES = 1,
   parameter int RES_ADDR      = 14
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [7:0]  req_a,
   input  logic [7:0]  req_b,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [15:0] rsp_product,
   output logic [7:0]  txn_count,
   output logic [7:0]  dut_ui_in,
   output logic [7:0]  dut_uio_in,
   input  logic [7:0]  dut_uo_out
);

   // Handshakes: a transfer happens on a rising clk edge where valid && ready;
   // the request side is ready only in IDLE, and a response stays valid with
   // stable data until rsp_ready is seen.

   localparam int WAIT_MAX = (INIT_WAIT > SETTLE_CYCLES) ? INIT_WAIT : SETTLE_CYCLES;
   localparam int WAIT_W   = (WAIT_MAX > 2) ? $clog2(WAIT_MAX) : 1;
   localparam logic [WAIT_W-1:0] INIT_LAST   = WAIT_W'(INIT_WAIT - 1);
   localparam logic [WAIT_W-1:0] SETTLE_LAST = WAIT_W'(SETTLE_CYCLES - 1);
   localparam logic [7:0] WR_A_UI = 8'(1 << WR_BIT) | 8'(OP_A_ADDR);
   localparam logic [7:0] WR_B_UI = 8'(1 << WR_BIT) | 8'(OP_B_ADDR);

   state_e              state_q, state_d;
   logic [WAIT_W-1:0]   wait_q, wait_d;
   logic [7:0]          a_q, a_d, b_q, b_d, lo_q, lo_d;
   logic [7:0]          ui_q, ui_d, uio_q, uio_d, txn_q, txn_d;
   logic [15:0]         product_q, product_d;
   logic                req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d;

   always_comb begin
      state_d     = state_q;
      wait_d      = wait_q;
      a_d         = a_q;
      b_d         = b_q;
      lo_d        = lo_q;
      product_d   = product_q;
      rsp_valid_d = rsp_valid_q;
      txn_d       = txn_q;
      case (state_q)
         ST_INIT: begin
            if (wait_q == INIT_LAST) begin
               state_d = ST_IDLE;
               wait_d  = '0;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         ST_IDLE: begin
            if (req_valid) begin
               a_d     = req_a;
               b_d     = req_b;
               state_d = ST_WR_A;
            end
         end
         ST_WR_A: state_d = ST_WR_B;
         ST_WR_B: begin
            state_d = ST_SETTLE;
            wait_d  = '0;
         end
         ST_SETTLE: begin
            if (wait_q == SETTLE_LAST) begin
               state_d = ST_RD_LO;
               wait_d  = '0;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         ST_RD_LO: state_d = ST_RD_HI;
         // uo_out lags the address by one cycle, so lo arrives while driving hi.
         ST_RD_HI: begin
            lo_d    = dut_uo_out;
            state_d = ST_CAP_HI;
         end
         ST_CAP_HI: begin
            product_d   = {dut_uo_out, lo_q};
            rsp_valid_d = 1'b1;
            state_d     = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               txn_d       = txn_q + 8'd1;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_INIT;
      endcase

      // Pin and ready registers carry the drive value of the state being entered.
      ui_d        = IDLE_UI;
      uio_d       = 8'h00;
      req_ready_d = (state_d == ST_IDLE);
      case (state_d)
         ST_WR_A: begin
            ui_d  = WR_A_UI;
            uio_d = a_d;
         end
         ST_WR_B: begin
            ui_d  = WR_B_UI;
            uio_d = b_d;
         end
         ST_RD_LO: ui_d = 8'(RES_ADDR);
         ST_RD_HI: ui_d = 8'(RES_ADDR + 1);
         default:  ui_d = IDLE_UI;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_INIT;
         wait_q      <= '0;
         a_q         <= 8'h00;
         b_q         <= 8'h00;
         lo_q        <= 8'h00;
         product_q   <= 16'h0000;
         rsp_valid_q <= 1'b0;
         req_ready_q <= 1'b0;
         txn_q       <= 8'h00;
         ui_q        <= IDLE_UI;
         uio_q       <= 8'h00;
      end else begin
         state_q     <= state_d;
         wait_q      <= wait_d;
         a_q         <= a_d;
         b_q         <= b_d;
         lo_q        <= lo_d;
         product_q   <= product_d;
         rsp_valid_q <= rsp_valid_d;
         req_ready_q <= req_ready_d;
         txn_q       <= txn_d;
         ui_q        <= ui_d;
         uio_q       <= uio_d;
      end
   end

   assign req_ready   = req_ready_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_product = product_q;
   assign txn_count   = txn_q;
   assign dut_ui_in   = ui_q;
   assign dut_uio_in  = uio_q;

endmodule

// File: tb/tb_drum_host_driver.sv
// Directed and random bench for drum_host_driver with a pin-level tile model.
module tb_drum_host_driver;
   import drum_host_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        rsp_ready = 1'b1;
   logic [7:0]  req_a = 8'h00;
   logic [7:0]  req_b = 8'h00;
   logic [7:0]  dut_uo_out = 8'h00;
   logic        req_ready, rsp_valid;
   logic [15:0] rsp_product;
   logic [7:0]  txn_count, dut_ui_in, dut_uio_in;

   logic [7:0]  ram [32];
   logic [15:0] exp_q [$];
   int          checks = 0;
   int          failures = 0;
   int          exp_txn = 0;

   drum_host_driver dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_product(rsp_product),
      .txn_count(txn_count),
      .dut_ui_in(dut_ui_in), .dut_uio_in(dut_uio_in), .dut_uo_out(dut_uo_out)
   );

   always #5 clk = ~clk;

   initial begin
      for (int i = 0; i < 32; i++) ram[i] = 8'h00;
   end

   // Tile model: writes on wr_en, stores the product when operand B lands,
   // registered read when addr[4] is clear.
   always @(posedge clk) begin
      if (dut_ui_in[7]) begin
         ram[dut_ui_in[4:0]] <= dut_uio_in;
         if (dut_ui_in[4:0] == 5'd1) {ram[15], ram[14]} <= drum_ref(ram[0], dut_uio_in);
      end else if (!dut_ui_in[4]) begin
         dut_uo_out <= ram[dut_ui_in[4:0]];
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input int hold,
                          input logic [15:0] exp_p);
      int          n;
      logic [15:0] want;
      logic [7:0]  exp_ui [6];
      logic [7:0]  exp_uio [6];
      exp_ui  = '{8'h80, 8'h81, 8'h10, 8'h0E, 8'h0F, 8'h10};
      exp_uio = '{a, b, 8'h00, 8'h00, 8'h00, 8'h00};
      req_a = a;
      req_b = b;
      req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("req_ready_wait", req_ready, 1);
      if (!req_ready) begin
         req_valid = 1'b0;
         return;
      end
      exp_q.push_back(exp_p);
      rsp_ready = (hold == 0);
      @(negedge clk);
      req_valid = 1'b0;
      req_a = 8'($urandom);
      req_b = 8'($urandom);
      for (int i = 0; i < 6; i++) begin
         chk("pin_ui", dut_ui_in, exp_ui[i]);
         chk("pin_uio", dut_uio_in, exp_uio[i]);
         chk("early_rsp", rsp_valid, 0);
         chk("busy_ready", req_ready, 0);
         @(negedge clk);
      end
      n = 0;
      while (!rsp_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      // Accept edge counts as cycle 1, so rsp_valid must be up right here.
      chk("rsp_latency7", n, 0);
      want = exp_q.pop_front();
      chk("rsp_product", rsp_product, want);
      for (int i = 0; i < hold; i++) begin
         chk("bp_valid", rsp_valid, 1);
         chk("bp_product", rsp_product, want);
         chk("bp_ready", req_ready, 0);
         chk("bp_txn", txn_count, exp_txn);
         chk("bp_pins", {dut_ui_in, dut_uio_in}, 16'h1000);
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      exp_txn = (exp_txn + 1) % 256;
      chk("rsp_cleared", rsp_valid, 0);
      chk("txn_count", txn_count, exp_txn);
      chk("idle_ready", req_ready, 1);
   endtask

   initial begin
      logic [7:0] a, b;
      int hold;
      rst_n = 1'b0;
      req_valid = 1'b1;
      req_a = 8'h03;
      req_b = 8'h02;
      repeat (3) @(negedge clk);
      chk("rst_ui", dut_ui_in, 8'h10);
      chk("rst_uio", dut_uio_in, 8'h00);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_product", rsp_product, 16'h0000);
      chk("rst_txn", txn_count, 8'h00);

      // Init gating with a request already pending.
      rst_n = 1'b1;
      for (int i = 1; i < 8; i++) begin
         @(negedge clk);
         chk("init_ready_low", req_ready, 0);
         chk("init_pins", dut_ui_in, 8'h10);
      end
      @(negedge clk);
      chk("init_ready_rise", req_ready, 1);
      req_valid = 1'b0;

      run_txn(8'h03, 8'h02, 0, 16'h0006);
      run_txn(8'hFF, 8'h02, 0, 16'hFFFF);
      run_txn(8'h00, 8'h00, 0, 16'h0000);
      a = 8'($urandom);
      b = 8'($urandom);
      run_txn(a, b, 5, drum_ref(a, b));

      // Reset while reading the low result byte.
      req_a = 8'($urandom);
      req_b = 8'($urandom);
      req_valid = 1'b1;
      chk("mid_ready", req_ready, 1);
      @(negedge clk);
      req_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("mid_rd_lo_pins", dut_ui_in, 8'h0E);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_ui", dut_ui_in, 8'h10);
      chk("mid_uio", dut_uio_in, 8'h00);
      chk("mid_req_ready", req_ready, 0);
      chk("mid_rsp_valid", rsp_valid, 0);
      chk("mid_product", rsp_product, 16'h0000);
      chk("mid_txn", txn_count, 8'h00);
      exp_txn = 0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 1; i < 8; i++) begin
         @(negedge clk);
         chk("reinit_ready_low", req_ready, 0);
         chk("reinit_no_rsp", rsp_valid, 0);
      end
      @(negedge clk);
      chk("reinit_ready_rise", req_ready, 1);

      for (int t = 0; t < 300; t++) begin
         a = 8'($urandom);
         b = 8'($urandom);
         hold = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 3)) : 0;
         run_txn(a, b, hold, drum_ref(a, b));
      end
      chk("txn_wrap", txn_count, 8'd44);
      chk("scoreboard_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
